// File: rtl/note_tone_gen_if.sv
// rtl/note_tone_gen_if.sv - note command handshake between melody sequencer and tone generator
//
// Signals:
//   note_valid  sequencer -> generator  note command present
//   note_ready  generator -> sequencer  generator can accept a command
//   note_code   sequencer -> generator  4-bit pitch code (0 and 15 are rests)
//   note_beats  sequencer -> generator  4-bit duration in beats
// Modports: master (sequencer side), slave (tone generator side).
interface note_tone_gen_if;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_code;
  logic [3:0] note_beats;

  modport master (
    output note_valid,
    output note_code,
    output note_beats,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_code,
    input  note_beats,
    output note_ready
  );
endinterface

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - note command to square-wave tone generator for the speaker pin
//
// Accepts one note per handshake and, for beats * BEAT_CYCLES clocks, drives a
// 50 % square wave at the note's pitch (or holds low for rests), then pulses
// note_done for one cycle.
//
// Parameters:
//   CLK_HZ       system clock frequency, used to derive the half-period divisors
//   BEAT_CYCLES  clocks per beat
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   note       note command handshake (slave side)
//   speaker    registered square-wave output
//   busy       registered, high while a note is playing
//   note_done  registered one-cycle pulse at the end of each accepted note
module note_tone_gen #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 25_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  note_tone_gen_if.slave note,
  output logic           speaker,
  output logic           busy,
  output logic           note_done
);

  // C4 (code 1) has the lowest pitch and therefore the largest divisor.
  localparam int unsigned DIV_MAX = CLK_HZ / (2 * 262);
  localparam int          DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX + 1) : 1;
  localparam int          CYC_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BEAT_CYCLES - 1);

  // Every entry is a constant expression, so this folds into a small lookup table.
  function automatic logic [DIV_W-1:0] half_div(input logic [3:0] code);
    case (code)
      4'd1:    half_div = DIV_W'(CLK_HZ / (2 * 262));
      4'd2:    half_div = DIV_W'(CLK_HZ / (2 * 294));
      4'd3:    half_div = DIV_W'(CLK_HZ / (2 * 330));
      4'd4:    half_div = DIV_W'(CLK_HZ / (2 * 349));
      4'd5:    half_div = DIV_W'(CLK_HZ / (2 * 392));
      4'd6:    half_div = DIV_W'(CLK_HZ / (2 * 440));
      4'd7:    half_div = DIV_W'(CLK_HZ / (2 * 494));
      4'd8:    half_div = DIV_W'(CLK_HZ / (2 * 523));
      4'd9:    half_div = DIV_W'(CLK_HZ / (2 * 587));
      4'd10:   half_div = DIV_W'(CLK_HZ / (2 * 659));
      4'd11:   half_div = DIV_W'(CLK_HZ / (2 * 698));
      4'd12:   half_div = DIV_W'(CLK_HZ / (2 * 784));
      4'd13:   half_div = DIV_W'(CLK_HZ / (2 * 880));
      4'd14:   half_div = DIV_W'(CLK_HZ / (2 * 988));
      // Rests never toggle; a divisor of 1 keeps the half-period counter sane.
      default: half_div = DIV_W'(1);
    endcase
  endfunction

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t            state_q;
  logic [3:0]        code_q;
  logic [3:0]        beats_q;
  logic [3:0]        beat_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  half_cnt_q;
  logic [CYC_W-1:0]  cyc_cnt_q;
  logic              speaker_q;
  logic              busy_q;
  logic              done_q;

  logic rest;
  logic note_end;

  assign rest     = (code_q == 4'd0) || (code_q == 4'hF);
  // Last clock of the last beat; beats_q is never 0 while in PLAY.
  assign note_end = (cyc_cnt_q == CYC_LAST) && (beat_cnt_q == beats_q - 4'd1);

  assign note.note_ready = (state_q == IDLE);
  assign speaker         = speaker_q;
  assign busy            = busy_q;
  assign note_done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= 4'd0;
      beats_q    <= 4'd0;
      beat_cnt_q <= 4'd0;
      div_q      <= '0;
      half_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      speaker_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          speaker_q <= 1'b0;
          if (note.note_valid) begin
            code_q     <= note.note_code;
            beats_q    <= note.note_beats;
            div_q      <= half_div(note.note_code);
            half_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            beat_cnt_q <= 4'd0;
            if (note.note_beats != 4'd0) begin
              state_q <= PLAY;
              busy_q  <= 1'b1;
            end else begin
              // Zero-length note: acknowledge silently and stay ready.
              done_q <= 1'b1;
            end
          end
        end

        PLAY: begin
          if (half_cnt_q == div_q - 1'b1) begin
            half_cnt_q <= '0;
            if (!rest) begin
              speaker_q <= ~speaker_q;
            end
          end else begin
            half_cnt_q <= half_cnt_q + 1'b1;
          end

          if (cyc_cnt_q == CYC_LAST) begin
            cyc_cnt_q  <= '0;
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end

          // Ending the note wins over any toggle scheduled for the same edge.
          if (note_end) begin
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
